pipe_hazard_ctrl: RTL and testbench

Central stall/flush sequencer for the 5-stage pipeline.
- Drives the enable and flush/bubble controls of the PC, IF/ID, ID/EX, EX/MEM and MEM/WB registers.
- Detects load-use hazards and applies taken-branch/jump flushes.
- Freezes the pipeline while a multi-cycle data memory access completes.
- Inserts fetch bubbles while instruction memory is not ready.

---
 rtl/pipe_ctrl_pkg.sv | 22 ++
 rtl/pipe_load_use_detect.sv | 30 +++
 rtl/pipe_hazard_ctrl.sv | 174 +++++++++++++++++
 tb/tb_pipe_hazard_ctrl.sv | 157 +++++++++++++++
 4 files changed

// File: rtl/pipe_ctrl_pkg.sv
`default_nettype none
// ============================================================================
// Module   : pipe_ctrl_pkg
// Purpose  : Shared types and constants for the pipeline hazard controller
//            and related units such as the forwarding logic.
// Contents : REG_AW   - register-index width
//            REG_ZERO - index of the hard-wired zero register
//            state_e  - sequencer states (RUN / DMEM_WAIT)
// Revision : 1.0 - initial release
// ============================================================================
package pipe_ctrl_pkg;

  localparam int REG_AW = 5;
  localparam logic [REG_AW-1:0] REG_ZERO = 5'd0;

  typedef enum logic {
    RUN       = 1'b0,
    DMEM_WAIT = 1'b1
  } state_e;

endpackage
`default_nettype wire

// File: rtl/pipe_load_use_detect.sv
`default_nettype none
// ============================================================================
// Module   : pipe_load_use_detect
// Purpose  : Combinational load-use hazard comparator. Flags an ID-stage
//            instruction that reads the destination of a load still in EX.
// Ports    : idex_memread_i - EX instruction is a load
//            idex_rt_i      - load destination register
//            id_rs_i        - ID rs source field
//            id_rt_i        - ID rt source field
//            id_uses_rt_i   - ID instruction really reads rt
//            lu_o           - load-use hazard present
// Revision : 1.0 - initial release
// ============================================================================
module pipe_load_use_detect
  import pipe_ctrl_pkg::*;
(
  input  logic              idex_memread_i,
  input  logic [REG_AW-1:0] idex_rt_i,
  input  logic [REG_AW-1:0] id_rs_i,
  input  logic [REG_AW-1:0] id_rt_i,
  input  logic              id_uses_rt_i,
  output logic              lu_o
);

  // A load into the zero register produces nothing to wait for.
  assign lu_o = idex_memread_i && (idex_rt_i != REG_ZERO) &&
                ((idex_rt_i == id_rs_i) || (id_uses_rt_i && (idex_rt_i == id_rt_i)));

endmodule
`default_nettype wire

// File: rtl/pipe_hazard_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : pipe_hazard_ctrl
// Purpose  : Stall/flush sequencer for the 5-stage pipeline. Generates the
//            enable and bubble controls of PC, IF/ID, ID/EX, EX/MEM, MEM/WB
//            for load-use hazards, taken branches, jumps, instruction-memory
//            wait states and multi-cycle data-memory accesses.
// Ports    : clk, rst (async, active-low)
//            ID/EX hazard inputs : id_rs_i, id_rt_i, id_uses_rt_i,
//                                  idex_memread_i, idex_rt_i
//            control-flow inputs : ex_branch_taken_i, id_jump_i
//            memory handshakes   : exmem_memreq_i, dmem_ready_i, imem_ready_i
//            register controls   : pc_en_o, ifid_en_o, ifid_flush_o,
//                                  idex_en_o, idex_flush_o, exmem_en_o,
//                                  memwb_bubble_o
//            status              : err_timeout_o (sticky)
// Option   : PIPE_HAZARD_PERF_CNT_EN adds stall_cycles_o / flush_events_o.
// Revision : 1.0 - initial release
// ============================================================================
module pipe_hazard_ctrl
  import pipe_ctrl_pkg::*;
#(
  parameter int DMEM_TIMEOUT = 64,
  parameter int CNT_W        = 7
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [REG_AW-1:0] id_rs_i,
  input  logic [REG_AW-1:0] id_rt_i,
  input  logic              id_uses_rt_i,
  input  logic              idex_memread_i,
  input  logic [REG_AW-1:0] idex_rt_i,
  input  logic              ex_branch_taken_i,
  input  logic              id_jump_i,
  input  logic              exmem_memreq_i,
  input  logic              dmem_ready_i,
  input  logic              imem_ready_i,
  output logic              pc_en_o,
  output logic              ifid_en_o,
  output logic              ifid_flush_o,
  output logic              idex_en_o,
  output logic              idex_flush_o,
  output logic              exmem_en_o,
  output logic              memwb_bubble_o,
`ifdef PIPE_HAZARD_PERF_CNT_EN
  output logic [31:0]       stall_cycles_o,
  output logic [31:0]       flush_events_o,
`endif
  output logic              err_timeout_o
);

  localparam logic [CNT_W-1:0] TIMEOUT_CNT = CNT_W'(DMEM_TIMEOUT);

  state_e           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             err_q, err_d;
  logic             lu;
  logic             freeze;

  pipe_load_use_detect u_lu (
    .idex_memread_i (idex_memread_i),
    .idex_rt_i      (idex_rt_i),
    .id_rs_i        (id_rs_i),
    .id_rt_i        (id_rt_i),
    .id_uses_rt_i   (id_uses_rt_i),
    .lu_o           (lu)
  );

  // The release cycle (DMEM_WAIT with dmem_ready) is not a freeze: every
  // stage advances so MEM/WB captures the load data.
  assign freeze = !dmem_ready_i && ((state_q == DMEM_WAIT) || exmem_memreq_i);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= RUN;
      cnt_q   <= '0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      err_q   <= err_d;
    end
  end

  always_comb begin
    state_d        = state_q;
    cnt_d          = cnt_q;
    err_d          = err_q;
    pc_en_o        = 1'b1;
    ifid_en_o      = 1'b1;
    ifid_flush_o   = 1'b0;
    idex_en_o      = 1'b1;
    idex_flush_o   = 1'b0;
    exmem_en_o     = 1'b1;
    memwb_bubble_o = 1'b0;

    // Next state and wait counter
    case (state_q)
      RUN: begin
        cnt_d = '0;
        if (exmem_memreq_i && !dmem_ready_i) state_d = DMEM_WAIT;
      end
      DMEM_WAIT: begin
        if (dmem_ready_i) begin
          state_d = RUN;
          cnt_d   = '0;
        end else if (cnt_q != TIMEOUT_CNT) begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      default: begin
        state_d = RUN;
        cnt_d   = '0;
      end
    endcase
    // Timeout is only reported; the access is never aborted.
    if (cnt_d == TIMEOUT_CNT) err_d = 1'b1;

    // Pipeline controls, highest priority first
    if (!rst) begin
      pc_en_o        = 1'b0;
      ifid_en_o      = 1'b0;
      ifid_flush_o   = 1'b1;
      idex_en_o      = 1'b0;
      idex_flush_o   = 1'b1;
      exmem_en_o     = 1'b0;
      memwb_bubble_o = 1'b1;
    end else if (freeze) begin
      pc_en_o        = 1'b0;
      ifid_en_o      = 1'b0;
      idex_en_o      = 1'b0;
      exmem_en_o     = 1'b0;
      memwb_bubble_o = 1'b1;
    end else if (ex_branch_taken_i) begin
      // ID instruction is wrong-path, so its hazards and jumps are moot.
      ifid_flush_o = 1'b1;
      idex_flush_o = 1'b1;
    end else begin
      if (lu) begin
        pc_en_o      = 1'b0;
        ifid_en_o    = 1'b0;
        idex_flush_o = 1'b1;
      end else if (id_jump_i) begin
        ifid_flush_o = 1'b1;
      end
      if (!imem_ready_i) begin
        pc_en_o = 1'b0;
        // A held IF/ID (load-use) must keep its instruction, not bubble.
        if (!lu) ifid_flush_o = 1'b1;
      end
    end
  end

  assign err_timeout_o = err_q;

`ifdef PIPE_HAZARD_PERF_CNT_EN
  logic [31:0] stall_q, flush_q;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      stall_q <= '0;
      flush_q <= '0;
    end else begin
      if (!pc_en_o)                     stall_q <= stall_q + 32'd1;
      if (ifid_flush_o || idex_flush_o) flush_q <= flush_q + 32'd1;
    end
  end

  assign stall_cycles_o = stall_q;
  assign flush_events_o = flush_q;
`endif

endmodule
`default_nettype wire

// File: tb/tb_pipe_hazard_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : tb_pipe_hazard_ctrl
// Purpose  : Self-checking bench for pipe_hazard_ctrl (DMEM_TIMEOUT=4).
//            Stimulus pushes the expected control vector
//            {pc_en, ifid_en, ifid_flush, idex_en, idex_flush, exmem_en,
//             memwb_bubble, err_timeout} into a queue; the monitor pops and
//            compares on each falling edge.
// Revision : 1.0 - initial release
// ============================================================================
module tb_pipe_hazard_ctrl;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic [4:0] id_rs, id_rt, idex_rt;
  logic       id_uses_rt, idex_memread, ex_branch_taken, id_jump;
  logic       exmem_memreq, dmem_ready, imem_ready;
  logic       pc_en, ifid_en, ifid_flush, idex_en, idex_flush, exmem_en;
  logic       memwb_bubble, err_timeout;

  int errors = 0;
  int checks = 0;

  logic [7:0] q_e[$];
  string      q_n[$];

  // Expected control vectors
  localparam logic [7:0] E_RST   = 8'b0010_1010;
  localparam logic [7:0] E_NORM  = 8'b1101_0100;
  localparam logic [7:0] E_NORME = 8'b1101_0101;
  localparam logic [7:0] E_LU    = 8'b0001_1100;
  localparam logic [7:0] E_FRZ   = 8'b0000_0010;
  localparam logic [7:0] E_FRZE  = 8'b0000_0011;
  localparam logic [7:0] E_BR    = 8'b1111_1100;
  localparam logic [7:0] E_JMP   = 8'b1111_0100;
  localparam logic [7:0] E_IMEM  = 8'b0111_0100;

  always #5 clk = ~clk;

  pipe_hazard_ctrl #(.DMEM_TIMEOUT(4), .CNT_W(3)) dut (
    .clk               (clk),
    .rst               (rst),
    .id_rs_i           (id_rs),
    .id_rt_i           (id_rt),
    .id_uses_rt_i      (id_uses_rt),
    .idex_memread_i    (idex_memread),
    .idex_rt_i         (idex_rt),
    .ex_branch_taken_i (ex_branch_taken),
    .id_jump_i         (id_jump),
    .exmem_memreq_i    (exmem_memreq),
    .dmem_ready_i      (dmem_ready),
    .imem_ready_i      (imem_ready),
    .pc_en_o           (pc_en),
    .ifid_en_o         (ifid_en),
    .ifid_flush_o      (ifid_flush),
    .idex_en_o         (idex_en),
    .idex_flush_o      (idex_flush),
    .exmem_en_o        (exmem_en),
    .memwb_bubble_o    (memwb_bubble),
    .err_timeout_o     (err_timeout)
  );

  // Monitor
  always @(negedge clk) begin
    logic [7:0] act, e;
    string      n;
    if (q_e.size() > 0) begin
      e   = q_e.pop_front();
      n   = q_n.pop_front();
      act = {pc_en, ifid_en, ifid_flush, idex_en, idex_flush, exmem_en,
             memwb_bubble, err_timeout};
      checks++;
      if (act !== e) begin
        errors++;
        $display("FAIL %s: got %b expected %b", n, act, e);
      end
    end
  end

  // Start a new cycle with idle inputs (rst left untouched).
  task automatic next();
    @(posedge clk);
    #1;
    id_rs = 5'd0; id_rt = 5'd0; id_uses_rt = 1'b0;
    idex_memread = 1'b0; idex_rt = 5'd0;
    ex_branch_taken = 1'b0; id_jump = 1'b0;
    exmem_memreq = 1'b0; dmem_ready = 1'b1; imem_ready = 1'b1;
  endtask

  task automatic expect_v(input logic [7:0] e, input string n);
    q_e.push_back(e);
    q_n.push_back(n);
  endtask

  initial begin
    next(); expect_v(E_RST, "reset0");
    next(); expect_v(E_RST, "reset1");
    next(); rst = 1'b1; expect_v(E_NORM, "idle");

    // Load-use on rs: exactly one bubble
    next(); idex_memread = 1'b1; idex_rt = 5'd8; id_rs = 5'd8; expect_v(E_LU, "lu_rs");
    next(); id_rs = 5'd8; expect_v(E_NORM, "lu_rs_release");
    // Load-use on rt, and rt match ignored when rt is not a source
    next(); idex_memread = 1'b1; idex_rt = 5'd9; id_rt = 5'd9; id_uses_rt = 1'b1; expect_v(E_LU, "lu_rt");
    next(); idex_memread = 1'b1; idex_rt = 5'd9; id_rt = 5'd9; expect_v(E_NORM, "rt_unused");
    // Load into $zero never stalls
    next(); idex_memread = 1'b1; expect_v(E_NORM, "lu_zero");

    // Data-memory freeze for 3 cycles, branch ignored while frozen
    next(); exmem_memreq = 1'b1; dmem_ready = 1'b0; expect_v(E_FRZ, "dmem_frz1");
    next(); exmem_memreq = 1'b1; dmem_ready = 1'b0; ex_branch_taken = 1'b1; expect_v(E_FRZ, "dmem_frz2");
    next(); exmem_memreq = 1'b1; dmem_ready = 1'b0; expect_v(E_FRZ, "dmem_frz3");
    next(); exmem_memreq = 1'b1; expect_v(E_NORM, "dmem_release");

    // Branch beats load-use; jump; instruction-memory wait
    next(); ex_branch_taken = 1'b1; idex_memread = 1'b1; idex_rt = 5'd8; id_rs = 5'd8; expect_v(E_BR, "branch_lu");
    next(); id_jump = 1'b1; expect_v(E_JMP, "jump");
    next(); imem_ready = 1'b0; expect_v(E_IMEM, "imem1");
    next(); imem_ready = 1'b0; expect_v(E_IMEM, "imem2");
    next(); imem_ready = 1'b0; idex_memread = 1'b1; idex_rt = 5'd3; id_rs = 5'd3; expect_v(E_LU, "imem_lu");
    next(); imem_ready = 1'b0; id_jump = 1'b1; expect_v(E_IMEM, "imem_jump");
    next(); id_jump = 1'b1; idex_memread = 1'b1; idex_rt = 5'd4; id_rs = 5'd4; expect_v(E_LU, "lu_over_jump");

    // Timeout: 4 stalled cycles in DMEM_WAIT raise the sticky flag
    next(); exmem_memreq = 1'b1; dmem_ready = 1'b0; expect_v(E_FRZ, "to_enter");
    for (int i = 0; i < 4; i++) begin
      next(); exmem_memreq = 1'b1; dmem_ready = 1'b0; expect_v(E_FRZ, "to_wait");
    end
    next(); exmem_memreq = 1'b1; dmem_ready = 1'b0; expect_v(E_FRZE, "to_err");
    next(); exmem_memreq = 1'b1; expect_v(E_NORME, "to_release");
    next(); expect_v(E_NORME, "to_sticky");
    next(); rst = 1'b0; expect_v(E_RST, "to_reset");
    next(); rst = 1'b1; expect_v(E_NORM, "to_cleared");

    // Reset in the middle of a wait returns to RUN with counter cleared
    next(); exmem_memreq = 1'b1; dmem_ready = 1'b0; expect_v(E_FRZ, "mid_enter");
    next(); exmem_memreq = 1'b1; dmem_ready = 1'b0; expect_v(E_FRZ, "mid_wait");
    next(); rst = 1'b0; dmem_ready = 1'b0; expect_v(E_RST, "mid_reset");
    next(); rst = 1'b1; dmem_ready = 1'b0; expect_v(E_NORM, "mid_run");
    next(); exmem_memreq = 1'b1; dmem_ready = 1'b0; expect_v(E_FRZ, "cnt_enter");
    for (int i = 0; i < 3; i++) begin
      next(); exmem_memreq = 1'b1; dmem_ready = 1'b0; expect_v(E_FRZ, "cnt_wait");
    end
    next(); exmem_memreq = 1'b1; expect_v(E_NORM, "cnt_cleared");

    // Drain the scoreboard with a bounded wait
    for (int i = 0; i < 10 && q_e.size() > 0; i++) @(posedge clk);
    if (q_e.size() > 0) begin
      errors++;
      $display("FAIL drain: got %0d pending expected 0", q_e.size());
    end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
`default_nettype wire
